// File: rtl/mm_pkg.sv
// Shared types and constants for the tiled matrix accumulation buffer.
// Holds the FSM state encoding and the width constants for the adder.
package mm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // One extra bit holds the carry needed to detect signed overflow.
  localparam int SAT_GUARD = 1;

endpackage

// File: rtl/sat_add.sv
// Signed adder that either wraps modulo 2^DW or clamps to the signed range.
// One instance serves one element of an input tile.
module sat_add
  import mm_pkg::*;
#(
  parameter int DW  = 32,
  parameter bit SAT = 1'b0
) (
  input  logic signed [DW-1:0] i_a,
  input  logic signed [DW-1:0] i_b,
  output logic signed [DW-1:0] o_sum
);

  localparam int SW = DW + SAT_GUARD;

  localparam logic [DW-1:0] MAX_V = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MIN_V = {1'b1, {(DW-1){1'b0}}};

  logic signed [SW-1:0] w_full;
  logic                 w_ovf;

  assign w_full = SW'(i_a) + SW'(i_b);
  assign w_ovf  = w_full[SW-1] != w_full[DW-1];

  always_comb begin
    o_sum = w_full[DW-1:0];
    if (SAT && w_ovf)
      o_sum = w_full[SW-1] ? MIN_V : MAX_V;
  end

endmodule

// File: rtl/mm_accum_buf.sv
// Tiled matrix result buffer: accumulates M_TILE x N_TILE beats into an
// M x N signed array, then drains it one row per handshake while zeroing.
module mm_accum_buf
  import mm_pkg::*;
#(
  parameter int M      = 16,
  parameter int N      = 16,
  parameter int M_TILE = 4,
  parameter int N_TILE = 4,
  parameter int DW_ADD = 32,
  parameter int DW_INT = 8,
  parameter int SAT    = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_first,
  input  logic [DW_INT-1:0]               ptr_row,
  input  logic [DW_INT-1:0]               ptr_col,
  input  logic [DW_ADD*M_TILE*N_TILE-1:0] in,
  input  logic                            drain,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DW_ADD*N-1:0]             out,
  output logic [DW_INT-1:0]               out_row,
  output logic                            out_last,
  output logic                            busy,
  output logic                            err
);

  localparam int T  = M_TILE * N_TILE;
  localparam int AW = $clog2(M * N);

  localparam logic [DW_INT-1:0] LAST_ROW = DW_INT'(M - 1);

  state_e                   r_state;
  logic signed [DW_ADD-1:0] r_buf [M*N];
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic                     r_out_last;
  logic                     r_busy;
  logic                     r_err;
  logic [DW_INT-1:0]        r_out_row;

  logic                     w_accept;
  logic                     w_in_range;
  logic                     w_hs;
  logic [AW-1:0]            w_row_base;
  logic [AW-1:0]            w_addr [T];
  logic signed [DW_ADD-1:0] w_sum  [T];

  assign w_accept   = in_valid & r_in_ready & enable;
  assign w_hs       = r_out_valid & out_ready & enable;
  assign w_in_range = (int'(ptr_row) < M / M_TILE)
                   && (int'(ptr_col) < N / N_TILE);
  assign w_row_base = AW'(int'(r_out_row) * N);

  // Out-of-range beats still need a legal read index; they never write.
  always_comb begin
    for (int i = 0; i < M_TILE; i++) begin
      for (int j = 0; j < N_TILE; j++) begin
        if (w_in_range)
          w_addr[i*N_TILE+j] = AW'((int'(ptr_row) * M_TILE + i) * N
                             + int'(ptr_col) * N_TILE + j);
        else
          w_addr[i*N_TILE+j] = AW'(i * N + j);
      end
    end
  end

  for (genvar k = 0; k < T; k++) begin : g_add
    logic signed [DW_ADD-1:0] w_a;
    logic signed [DW_ADD-1:0] w_b;

    assign w_a = in_first ? '0 : r_buf[w_addr[k]];
    assign w_b = in[DW_ADD*k +: DW_ADD];

    sat_add #(
      .DW  (DW_ADD),
      .SAT (SAT != 0)
    ) u_add (
      .i_a   (w_a),
      .i_b   (w_b),
      .o_sum (w_sum[k])
    );
  end

  always_comb begin
    out = '0;
    for (int c = 0; c < N; c++)
      out[DW_ADD*c +: DW_ADD] = r_buf[w_row_base + AW'(c)];
  end

  // Beats are only accepted outside DRAIN, so write and zero never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < M*N; k++)
        r_buf[k] <= '0;
    end else if (enable) begin
      if (w_accept && w_in_range) begin
        for (int k = 0; k < T; k++)
          r_buf[w_addr[k]] <= w_sum[k];
      end
      if (w_hs) begin
        for (int c = 0; c < N; c++)
          r_buf[w_row_base + AW'(c)] <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_row   <= '0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else if (enable) begin
      if (w_accept && !w_in_range)
        r_err <= 1'b1;
      unique case (r_state)
        ST_IDLE, ST_ACCUM: begin
          if (drain) begin
            r_state     <= ST_DRAIN;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b1;
            r_out_row   <= '0;
            r_out_last  <= (M == 1);
            r_busy      <= 1'b1;
          end else if (w_accept) begin
            r_state <= ST_ACCUM;
            r_busy  <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (r_out_last) begin
              r_state     <= ST_IDLE;
              r_in_ready  <= 1'b1;
              r_out_valid <= 1'b0;
              r_out_row   <= '0;
              r_out_last  <= 1'b0;
              r_busy      <= 1'b0;
            end else begin
              r_out_row  <= r_out_row + DW_INT'(1);
              r_out_last <= (r_out_row + DW_INT'(1)) == LAST_ROW;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_row   = r_out_row;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

// File: tb/tb_mm_accum_buf.sv
// Directed bench for mm_accum_buf: default 32-bit build plus two
// 8-bit builds (saturating and wrapping) for overflow behaviour.
module tb_mm_accum_buf;

  localparam int DW = 32;
  localparam int M  = 16;
  localparam int N  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, enable, in_valid, in_first, drain, out_ready;
  logic [7:0]        ptr_row, ptr_col;
  logic [DW*16-1:0]  m_in;
  logic              in_ready, out_valid, out_last, busy, err;
  logic [DW*N-1:0]   m_out;
  logic [7:0]        out_row;

  logic              d_valid, d_first, d_drain;
  logic [7:0]        d_prow, d_pcol;
  logic [127:0]      d_in;
  logic              s1_ir, s1_ov, s1_last, s1_busy, s1_err;
  logic              s0_ir, s0_ov, s0_last, s0_busy, s0_err;
  logic [31:0]       s1_out, s0_out;
  logic [7:0]        s1_row, s0_row;
  logic [7:0]        bv, e1, e0;

  int checks = 0;
  int errors = 0;
  int exp_m [M][N];

  mm_accum_buf dut (
    .clk(clk), .reset(reset), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
    .ptr_row(ptr_row), .ptr_col(ptr_col), .in(m_in),
    .drain(drain), .out_valid(out_valid), .out_ready(out_ready),
    .out(m_out), .out_row(out_row), .out_last(out_last),
    .busy(busy), .err(err)
  );

  mm_accum_buf #(
    .M(8), .N(4), .M_TILE(4), .N_TILE(4), .DW_ADD(8), .SAT(1)
  ) dut_s1 (
    .clk(clk), .reset(reset), .enable(enable),
    .in_valid(d_valid), .in_ready(s1_ir), .in_first(d_first),
    .ptr_row(d_prow), .ptr_col(d_pcol), .in(d_in),
    .drain(d_drain), .out_valid(s1_ov), .out_ready(out_ready),
    .out(s1_out), .out_row(s1_row), .out_last(s1_last),
    .busy(s1_busy), .err(s1_err)
  );

  mm_accum_buf #(
    .M(8), .N(4), .M_TILE(4), .N_TILE(4), .DW_ADD(8), .SAT(0)
  ) dut_s0 (
    .clk(clk), .reset(reset), .enable(enable),
    .in_valid(d_valid), .in_ready(s0_ir), .in_first(d_first),
    .ptr_row(d_prow), .ptr_col(d_pcol), .in(d_in),
    .drain(d_drain), .out_valid(s0_ov), .out_ready(out_ready),
    .out(s0_out), .out_row(s0_row), .out_last(s0_last),
    .busy(s0_busy), .err(s0_err)
  );

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] row_vec(input int r);
    logic [511:0] v;
    v = '0;
    for (int c = 0; c < N; c++)
      v[DW*c +: DW] = DW'(exp_m[r][c]);
    return v;
  endfunction

  task automatic beat(input int pr, input int pc, input int val,
                      input bit first, input bit with_drain);
    ptr_row  = 8'(pr);
    ptr_col  = 8'(pc);
    in_first = first;
    drain    = with_drain;
    in_valid = 1'b1;
    for (int k = 0; k < 16; k++)
      m_in[DW*k +: DW] = DW'(val);
    step;
    in_valid = 1'b0;
    drain    = 1'b0;
    in_first = 1'b0;
    if (pr < 4 && pc < 4) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          exp_m[pr*4+i][pc*4+j] = first ? val
                                : exp_m[pr*4+i][pc*4+j] + val;
    end
  endtask

  task automatic start_drain;
    drain = 1'b1;
    step;
    drain = 1'b0;
  endtask

  task automatic drain_rows(input int stall_row);
    for (int r = 0; r < M; r++) begin
      chk("out_valid", out_valid, 1);
      chk("out_row", out_row, r);
      chk("out_last", out_last, r == M - 1);
      chk("row_data", m_out, row_vec(r));
      if (r == stall_row) begin
        out_ready = 1'b0;
        step;
        step;
        chk("hold_row", out_row, r);
        chk("hold_data", m_out, row_vec(r));
        chk("hold_valid", out_valid, 1);
        out_ready = 1'b1;
      end
      step;
    end
    chk("drain_done", out_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_ready", in_ready, 1);
    exp_m = '{default: 0};
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; in_first = 1'b0;
    drain = 1'b0; out_ready = 1'b1; ptr_row = '0; ptr_col = '0;
    m_in = '0; d_valid = 1'b0; d_first = 1'b0; d_drain = 1'b0;
    d_prow = '0; d_pcol = '0; d_in = '0;
    exp_m = '{default: 0};
    step;
    step;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;

    // single beat of ones at tile (0,0)
    beat(0, 0, 1, 1'b0, 1'b0);
    chk("accum_busy", busy, 1);
    chk("accum_ready", in_ready, 1);
    start_drain;
    chk("drain_ready", in_ready, 0);
    drain_rows(-1);

    // overwrite then back-to-back accumulate, beat coincident with drain
    beat(3, 3, 5, 1'b1, 1'b0);
    beat(3, 3, 5, 1'b0, 1'b0);
    beat(3, 3, 5, 1'b0, 1'b0);
    beat(3, 3, 5, 1'b0, 1'b0);
    beat(1, 2, 7, 1'b0, 1'b1);
    drain_rows(-1);

    // out-of-range row pointer
    beat(4, 0, 9, 1'b0, 1'b0);
    chk("err_set", err, 1);
    start_drain;
    drain_rows(-1);
    chk("err_sticky", err, 1);

    // backpressure on row 1, then a drain of an emptied buffer
    beat(0, 1, 3, 1'b0, 1'b0);
    start_drain;
    drain_rows(1);
    start_drain;
    drain_rows(-1);

    // reset in the middle of a drain
    beat(2, 0, 2, 1'b0, 1'b0);
    beat(3, 3, 2, 1'b0, 1'b0);
    start_drain;
    for (int k = 0; k < 7; k++) step;
    chk("mid_row", out_row, 7);
    reset = 1'b1;
    step;
    reset = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_row", out_row, 0);
    chk("abort_ready", in_ready, 1);
    chk("abort_err", err, 0);
    exp_m = '{default: 0};
    start_drain;
    drain_rows(-1);

    // 8-bit overflow: +100+100 on tile 0, -100-100 on tile 1
    d_valid = 1'b1;
    d_prow  = 8'd0;
    bv      = 8'd100;
    d_in    = {16{bv}};
    step;
    step;
    d_prow  = 8'd1;
    bv      = 8'h9C;
    d_in    = {16{bv}};
    step;
    step;
    d_valid = 1'b0;
    d_drain = 1'b1;
    step;
    d_drain = 1'b0;
    for (int r = 0; r < 8; r++) begin
      e1 = (r < 4) ? 8'h7F : 8'h80;
      e0 = (r < 4) ? 8'hC8 : 8'h38;
      chk("sat_valid", s1_ov, 1);
      chk("wrap_valid", s0_ov, 1);
      chk("sat_row", s1_out, {4{e1}});
      chk("wrap_row", s0_out, {4{e0}});
      chk("sat_last", s1_last, r == 7);
      step;
    end
    chk("sat_idle", s1_busy, 0);
    chk("wrap_idle", s0_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
